// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: merges single writes (A) and paired writes (B) onto a two-port
// register-file write interface through per-requester FIFOs with round-robin grant.
module regfile_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [3:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [3:0]  b_addr_lo,
    input  logic [3:0]  b_addr_hi,
    input  logic [31:0] b_data_lo,
    input  logic [31:0] b_data_hi,
    output logic [1:0]  we3,
    output logic [3:0]  wa3,
    output logic [3:0]  wa3_2,
    output logic [31:0] wd3,
    output logic [31:0] wd3_2,
    output logic [14:0] pending_mask,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {GRANT_A, GRANT_B} grant_t;

    grant_t      last_grant;
    logic [AW:0] a_wr, a_rd, b_wr, b_rd;
    logic [AW:0] a_cnt, b_cnt;
    logic        a_empty, b_empty, a_full, b_full;
    logic        a_illegal, b_illegal, b_same;
    logic        a_push, b_push, pop_a, pop_b, bad_req;
    logic [AW-1:0] a_off, b_off;

    logic [3:0]  a_addr_mem [DEPTH];
    logic [31:0] a_data_mem [DEPTH];
    logic [3:0]  b_lo_addr_mem [DEPTH];
    logic [3:0]  b_hi_addr_mem [DEPTH];
    logic [31:0] b_lo_data_mem [DEPTH];
    logic [31:0] b_hi_data_mem [DEPTH];
    logic        b_single_mem [DEPTH];

    function automatic logic [14:0] decode(input logic [3:0] addr);
        decode = '0;
        if (addr != 4'hF) decode[addr] = 1'b1;
    endfunction

    assign a_cnt   = a_wr - a_rd;
    assign b_cnt   = b_wr - b_rd;
    assign a_empty = (a_wr == a_rd);
    assign b_empty = (b_wr == b_rd);
    assign a_full  = (a_wr[AW] != a_rd[AW]) && (a_wr[AW-1:0] == a_rd[AW-1:0]);
    assign b_full  = (b_wr[AW] != b_rd[AW]) && (b_wr[AW-1:0] == b_rd[AW-1:0]);
    assign a_ready = !a_full;
    assign b_ready = !b_full;

    // Writes to R15 (PC) are swallowed by the handshake but never queued.
    assign a_illegal = (a_addr == 4'hF);
    assign b_illegal = (b_addr_lo == 4'hF) || (b_addr_hi == 4'hF);
    assign b_same    = (b_addr_lo == b_addr_hi);
    assign a_push    = a_valid && a_ready && !a_illegal;
    assign b_push    = b_valid && b_ready && !b_illegal;
    assign bad_req   = (a_valid && a_ready && a_illegal) ||
                       (b_valid && b_ready && (b_illegal || b_same));

    assign pop_a = !a_empty && (b_empty || last_grant == GRANT_B);
    assign pop_b = !b_empty && !pop_a;

    always_ff @(posedge clk) begin
        if (a_push) begin
            a_addr_mem[a_wr[AW-1:0]] <= a_addr;
            a_data_mem[a_wr[AW-1:0]] <= a_data;
        end
        // A pair aimed at one register collapses to a single write of the hi word.
        if (b_push) begin
            b_lo_addr_mem[b_wr[AW-1:0]] <= b_same ? b_addr_hi : b_addr_lo;
            b_lo_data_mem[b_wr[AW-1:0]] <= b_same ? b_data_hi : b_data_lo;
            b_hi_addr_mem[b_wr[AW-1:0]] <= b_addr_hi;
            b_hi_data_mem[b_wr[AW-1:0]] <= b_data_hi;
            b_single_mem[b_wr[AW-1:0]]  <= b_same;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_wr       <= '0;
            a_rd       <= '0;
            b_wr       <= '0;
            b_rd       <= '0;
            last_grant <= GRANT_B;
            we3        <= 2'b00;
            wa3        <= '0;
            wa3_2      <= '0;
            wd3        <= '0;
            wd3_2      <= '0;
            err        <= 1'b0;
        end else begin
            if (a_push) a_wr <= a_wr + 1'b1;
            if (b_push) b_wr <= b_wr + 1'b1;
            if (bad_req) err <= 1'b1;
            if (pop_a) begin
                a_rd       <= a_rd + 1'b1;
                last_grant <= GRANT_A;
                we3        <= 2'b01;
                wa3        <= a_addr_mem[a_rd[AW-1:0]];
                wd3        <= a_data_mem[a_rd[AW-1:0]];
            end else if (pop_b) begin
                b_rd       <= b_rd + 1'b1;
                last_grant <= GRANT_B;
                wa3        <= b_lo_addr_mem[b_rd[AW-1:0]];
                wd3        <= b_lo_data_mem[b_rd[AW-1:0]];
                if (b_single_mem[b_rd[AW-1:0]]) begin
                    we3 <= 2'b01;
                end else begin
                    we3   <= 2'b11;
                    wa3_2 <= b_hi_addr_mem[b_rd[AW-1:0]];
                    wd3_2 <= b_hi_data_mem[b_rd[AW-1:0]];
                end
            end else begin
                we3 <= 2'b00;
            end
        end
    end

    // Entry i is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        pending_mask = '0;
        a_off        = '0;
        b_off        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            a_off = AW'(i) - a_rd[AW-1:0];
            b_off = AW'(i) - b_rd[AW-1:0];
            if ({1'b0, a_off} < a_cnt)
                pending_mask = pending_mask | decode(a_addr_mem[i]);
            if ({1'b0, b_off} < b_cnt) begin
                pending_mask = pending_mask | decode(b_lo_addr_mem[i]);
                if (!b_single_mem[i])
                    pending_mask = pending_mask | decode(b_hi_addr_mem[i]);
            end
        end
        if (we3 != 2'b00) pending_mask = pending_mask | decode(wa3);
        if (we3 == 2'b11) pending_mask = pending_mask | decode(wa3_2);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: each task drives one scenario and checks
// hand-computed register-file writes, pending mask, readiness and error flag.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [3:0]  a_addr = '0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [3:0]  b_addr_lo = '0;
    logic [3:0]  b_addr_hi = '0;
    logic [31:0] b_data_lo = '0;
    logic [31:0] b_data_hi = '0;
    logic [1:0]  we3;
    logic [3:0]  wa3, wa3_2;
    logic [31:0] wd3, wd3_2;
    logic [14:0] pending_mask;
    logic        err;

    int total = 0;
    int bad = 0;
    logic [73:0] wr_log [$];

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready),
        .b_addr_lo(b_addr_lo), .b_addr_hi(b_addr_hi),
        .b_data_lo(b_data_lo), .b_data_hi(b_data_hi),
        .we3(we3), .wa3(wa3), .wa3_2(wa3_2), .wd3(wd3), .wd3_2(wd3_2),
        .pending_mask(pending_mask), .err(err)
    );

    always #5 clk = ~clk;

    // Every issued write word, packed as {we3, wa3, wd3, wa3_2, wd3_2}.
    always @(negedge clk)
        if (reset_n && we3 != 2'b00) wr_log.push_back({we3, wa3, wd3, wa3_2, wd3_2});

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        wr_log.delete();
    endtask

    task automatic test_reset();
        #1;
        total++; if (we3 !== 2'b00) begin bad++; $display("[TB] FAIL reset_we3 got=%b want=00", we3); end
        total++; if ({wa3, wa3_2} !== 8'h00) begin bad++; $display("[TB] FAIL reset_addr got=%h/%h want=0/0", wa3, wa3_2); end
        total++; if ({wd3, wd3_2} !== 64'h0) begin bad++; $display("[TB] FAIL reset_data got=%h/%h want=0/0", wd3, wd3_2); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", err); end
        total++; if (pending_mask !== 15'h0) begin bad++; $display("[TB] FAIL reset_pending got=%h want=0", pending_mask); end
        tick();
        reset_n = 1'b1;
        tick();
        total++; if ({a_ready, b_ready} !== 2'b11) begin bad++; $display("[TB] FAIL reset_ready got=%b want=11", {a_ready, b_ready}); end
    endtask

    task automatic test_a_alone();
        a_valid = 1'b1; a_addr = 4'd3; a_data = 32'h1234;
        tick();
        a_valid = 1'b0;
        total++; if (we3 !== 2'b00) begin bad++; $display("[TB] FAIL alone_e1_we3 got=%b want=00", we3); end
        total++; if (pending_mask !== 15'h0008) begin bad++; $display("[TB] FAIL alone_e1_pending got=%h want=0008", pending_mask); end
        tick();
        total++; if ({we3, wa3, wd3} !== {2'b01, 4'd3, 32'h1234}) begin bad++; $display("[TB] FAIL alone_write got=%b/%h/%h want=01/3/00001234", we3, wa3, wd3); end
        total++; if (pending_mask !== 15'h0008) begin bad++; $display("[TB] FAIL alone_e2_pending got=%h want=0008", pending_mask); end
        tick();
        total++; if ({we3, wa3} !== {2'b00, 4'd3}) begin bad++; $display("[TB] FAIL alone_idle got=%b/%h want=00/3", we3, wa3); end
        total++; if (pending_mask !== 15'h0) begin bad++; $display("[TB] FAIL alone_idle_pending got=%h want=0", pending_mask); end
    endtask

    task automatic test_tie();
        do_reset();
        a_valid = 1'b1; a_addr = 4'd1; a_data = 32'hA;
        b_valid = 1'b1; b_addr_lo = 4'd2; b_addr_hi = 4'd3; b_data_lo = 32'hB0; b_data_hi = 32'hB1;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        total++; if (pending_mask !== 15'h000E) begin bad++; $display("[TB] FAIL tie_queued_pending got=%h want=000e", pending_mask); end
        tick();
        total++; if ({we3, wa3, wd3} !== {2'b01, 4'd1, 32'hA}) begin bad++; $display("[TB] FAIL tie_first_a got=%b/%h/%h want=01/1/0000000a", we3, wa3, wd3); end
        total++; if (pending_mask !== 15'h000E) begin bad++; $display("[TB] FAIL tie_a_pending got=%h want=000e", pending_mask); end
        tick();
        total++; if ({we3, wa3, wd3, wa3_2, wd3_2} !== {2'b11, 4'd2, 32'hB0, 4'd3, 32'hB1})
            begin bad++; $display("[TB] FAIL tie_second_b got=%b/%h/%h/%h/%h want=11/2/b0/3/b1", we3, wa3, wd3, wa3_2, wd3_2); end
        total++; if (pending_mask !== 15'h000C) begin bad++; $display("[TB] FAIL tie_b_pending got=%h want=000c", pending_mask); end
        tick();
        total++; if ({we3, wa3, wa3_2} !== {2'b00, 4'd2, 4'd3}) begin bad++; $display("[TB] FAIL tie_hold got=%b/%h/%h want=00/2/3", we3, wa3, wa3_2); end
    endtask

    task automatic test_full();
        int a_i = 0;
        int b_i = 0;
        int a_seen = 0;
        int b_seen = 0;
        int a_done;
        bit saw_full = 0;
        bit acc_a, acc_b;
        do_reset();
        for (int cyc = 0; cyc < 40 && wr_log.size() < 6; cyc++) begin
            a_valid = (a_i < 3); a_addr = 4'(4 + a_i); a_data = 32'hA0 + a_i;
            b_valid = (b_i < 3); b_addr_lo = 4'd7; b_addr_hi = 4'd8;
            b_data_lo = 32'hB0 + b_i; b_data_hi = 32'hC0 + b_i;
            if (!a_ready) begin
                a_done = 0;
                foreach (wr_log[k]) if (wr_log[k][73:72] == 2'b01) a_done++;
                saw_full = 1;
                total++; if (a_i - a_done != DEPTH) begin bad++; $display("[TB] FAIL full_occupancy got=%0d want=%0d", a_i - a_done, DEPTH); end
            end
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            tick();
            if (acc_a) a_i++;
            if (acc_b) b_i++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        total++; if (wr_log.size() != 6) begin bad++; $display("[TB] FAIL full_count got=%0d want=6", wr_log.size()); end
        total++; if (!saw_full) begin bad++; $display("[TB] FAIL full_ready got=never-low want=low-at-%0d", DEPTH); end
        foreach (wr_log[k]) begin
            if (wr_log[k][73:72] == 2'b01) begin
                total++;
                if (wr_log[k][71:36] !== {4'(4 + a_seen), 32'hA0 + a_seen})
                    begin bad++; $display("[TB] FAIL full_a_order got=%h want=%h", wr_log[k][71:36], {4'(4 + a_seen), 32'hA0 + a_seen}); end
                a_seen++;
            end else begin
                total++;
                if (wr_log[k] !== {2'b11, 4'd7, 32'hB0 + b_seen, 4'd8, 32'hC0 + b_seen})
                    begin bad++; $display("[TB] FAIL full_b_order got=%h want=%h", wr_log[k], {2'b11, 4'd7, 32'hB0 + b_seen, 4'd8, 32'hC0 + b_seen}); end
                b_seen++;
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        a_valid = 1'b1; a_addr = 4'hF; a_data = 32'hDEAD;
        tick();
        a_valid = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL illegal_err got=%b want=1", err); end
        total++; if (pending_mask !== 15'h0) begin bad++; $display("[TB] FAIL illegal_pending got=%h want=0", pending_mask); end
        tick();
        total++; if (we3 !== 2'b00) begin bad++; $display("[TB] FAIL illegal_nowrite got=%b want=00", we3); end
        b_valid = 1'b1; b_addr_lo = 4'd5; b_addr_hi = 4'd5; b_data_lo = 32'h55; b_data_hi = 32'h66;
        tick();
        b_valid = 1'b0;
        total++; if (pending_mask !== 15'h0020) begin bad++; $display("[TB] FAIL same_pending got=%h want=0020", pending_mask); end
        tick();
        total++; if ({we3, wa3, wd3, wa3_2} !== {2'b01, 4'd5, 32'h66, 4'd0})
            begin bad++; $display("[TB] FAIL same_write got=%b/%h/%h/%h want=01/5/00000066/0", we3, wa3, wd3, wa3_2); end
        b_valid = 1'b1; b_addr_lo = 4'd6; b_addr_hi = 4'hF;
        tick();
        b_valid = 1'b0;
        total++; if (pending_mask !== 15'h0) begin bad++; $display("[TB] FAIL b_pc_pending got=%h want=0", pending_mask); end
        tick();
        total++; if ({we3, err} !== {2'b00, 1'b1}) begin bad++; $display("[TB] FAIL b_pc_drop got=%b/%b want=00/1", we3, err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_valid = 1'b1; a_addr = 4'd9; a_data = 32'h99;
        b_valid = 1'b1; b_addr_lo = 4'd11; b_addr_hi = 4'd12; b_data_lo = 32'h11; b_data_hi = 32'h12;
        tick();
        a_addr = 4'd10; a_data = 32'h10A; b_valid = 1'b0;
        tick();
        a_valid = 1'b0;
        total++; if ({we3, wa3} !== {2'b01, 4'd9}) begin bad++; $display("[TB] FAIL mid_before got=%b/%h want=01/9", we3, wa3); end
        reset_n = 1'b0;
        #1;
        total++; if ({we3, wa3, err} !== {2'b00, 4'd0, 1'b0}) begin bad++; $display("[TB] FAIL mid_reset_out got=%b/%h/%b want=00/0/0", we3, wa3, err); end
        total++; if (pending_mask !== 15'h0) begin bad++; $display("[TB] FAIL mid_reset_pending got=%h want=0", pending_mask); end
        tick();
        reset_n = 1'b1;
        wr_log.delete();
        repeat (4) tick();
        total++; if (wr_log.size() != 0) begin bad++; $display("[TB] FAIL mid_no_replay got=%0d want=0", wr_log.size()); end
        total++; if ({a_ready, b_ready, pending_mask} !== {2'b11, 15'h0}) begin bad++; $display("[TB] FAIL mid_after got=%b%b/%h want=11/0", a_ready, b_ready, pending_mask); end
    endtask

    initial begin
        test_reset();
        test_a_alone();
        test_tie();
        test_full();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, 2, entries per requester FIFO (power of two, 2..8).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: a_valid  in  1  requester A (ALU/load) has a single write.
REQ-005 SHALL have port: a_ready  out  1  A FIFO can accept.
REQ-006 SHALL have port: a_addr  in  4  A destination register.
REQ-007 SHALL have port: a_data  in  32  A write data.
REQ-008 SHALL have port: b_valid  in  1  requester B (long multiply) has a paired write.
REQ-009 SHALL have port: b_ready  out  1  B FIFO can accept.
REQ-010 SHALL have port: b_addr_lo, b_addr_hi  in  4 each  B destinations (lo, hi).
REQ-011 SHALL have port: b_data_lo, b_data_hi  in  32 each  B write data.
REQ-012 SHALL have port: we3  out  2  regfile write enable (00 none, 01 single, 11 pair).
REQ-013 SHALL have port: wa3, wa3_2  out  4 each  regfile write addresses.
REQ-014 SHALL have port: wd3, wd3_2  out  32 each  regfile write data.
REQ-015 SHALL have port: pending_mask  out  15  bit i set while any write to Ri is queued or on outputs.
REQ-016 SHALL have port: err  out  1  sticky illegal-request flag.

Function
REQ-017 Handshake: transfer when valid && ready on posedge; ready = FIFO not full, independent of valid and of same-cycle pop (no pass-through).
REQ-018 Each requester SHALL have its own DEPTH-entry FIFO, in-order, wrap-around pointers with extra wrap bit for full/empty.
REQ-019 Each cycle, if any FIFO is non-empty, exactly one entry SHALL be popped and registered onto outputs; otherwise we3 <= 00 (addresses/data hold).
REQ-020 Arbitration: one non-empty FIFO -> it wins; both non-empty -> the requester not granted last wins (round-robin); last_grant updates only on a pop.
REQ-021 A pop drives we3=01, wa3=a_addr, wd3=a_data, wa3_2/wd3_2 unchanged; B pop drives we3=11, wa3=lo, wd3=lo data, wa3_2=hi, wd3_2=hi data.
REQ-022 Latency: a request accepted at edge N, with no competition, SHALL appear on outputs after edge N+1; max wait under contention = 2*DEPTH pops.
REQ-023 Address 4'hF (PC) on any A or B destination SHALL be accepted, discarded (not enqueued), and set err.
REQ-024 B request with b_addr_lo == b_addr_hi SHALL be enqueued as a single write of hi data (issued with we3=01) and set err.
REQ-025 pending_mask SHALL be the OR of decoded destinations of all valid FIFO entries plus the current output word when we3 != 00; combinational from registered state.
REQ-026 Simultaneous push and pop on same FIFO SHALL both occur; occupancy unchanged.
REQ-027 err SHALL remain 1 until reset.

Reset
REQ-028 reset_n low SHALL immediately clear FIFOs (empty), we3=00, wa3=wa3_2=0, wd3=wd3_2=0, err=0, last_grant=B (so A wins first tie), pending_mask=0.
REQ-029 Reset mid-operation SHALL drop all queued writes; no write issued in the cycle reset deasserts.
REQ-030 a_ready and b_ready SHALL be 1 from the first edge after reset release.

Verification
REQ-031 A alone: a_addr=3, a_data=0x1234 accepted edge 1 -> after edge 2 we3=01, wa3=3, wd3=0x1234; next cycle we3=00; pending_mask bit3 high from edge 1 through edge 2 output cycle.
REQ-032 Tie: A(R1,0xA) and B(R2/R3,0xB0/0xB1) accepted same edge -> outputs A first (we3=01), then B (we3=11, wa3=2, wa3_2=3).
REQ-033 Full: push DEPTH+1 A requests with arbiter output continuously popping held off by B contention -> a_ready=0 when DEPTH entries stored; no loss, in-order delivery.
REQ-034 Illegal: a_addr=15 accepted -> no write issued, err=1 and stays 1; b_addr_lo=b_addr_hi=5 -> single write we3=01, wa3=5, wd3=b_data_hi.
REQ-035 Reset with 2 entries queued -> we3=00, pending_mask=0 immediately; no queued write appears afterward.
